aes_out_fifo: RTL and testbench
===============================

# aes_out_fifo

Result buffer directly downstream of `aes_engine`. Every cycle it samples the engine's `out`/`out_type` pair. It captures valid ENCRYPT/DECRYPT results into a DEPTH-entry FIFO and presents them to the consumer over a valid/ready handshake. It drives `aes_engine.halt` to stall the engine before the buffer fills, and flags a sticky overflow error if a result arrives while the buffer is full.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥4.
- `SKID`, 2, free entries reserved for results already in flight when halt asserts; 1 ≤ SKID ≤ DEPTH-1.

- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `eng_out`  in  128  `aes_engine.out`.
- `eng_out_type`  in  job_t  `aes_engine.out_type` (job_t from `sysdef.svh`: ENCRYPT, DECRYPT, INVALID).
- `eng_halt`  out  1  to `aes_engine.halt`; registered.
- `m_valid`  out  1  head entry available.
- `m_ready`  in  1  consumer accepts head entry.
- `m_data`  out  128  head entry result block.
- `m_type`  out  job_t  head entry job type.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: a valid result was dropped.
- `clr_overflow`  in  1  synchronous clear of `overflow`.
- `enc_cnt`, `dec_cnt`  out  16 each  present only with `AES_OUT_FIFO_STATS_EN`.

## Operation
- The push condition is evaluated at every posedge: `eng_out_type` ∈ {ENCRYPT, DECRYPT}. INVALID is never stored.
- Pop condition: `m_valid && m_ready`.
- A push is accepted when `count < DEPTH`, or when `count == DEPTH` and a pop occurs in the same cycle.
- A push in any other case is dropped: the FIFO contents are unchanged, and `overflow` is set at the next posedge.
- Simultaneous push and pop: both take effect and `count` is unchanged.
- Simultaneous push and pop when empty is impossible, because `m_valid` is 0.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count` ranges 0..DEPTH.
- `m_valid = (count != 0)`. `m_data`/`m_type` are the entry at the read pointer.
- While `m_valid` is 0, `m_data` and `m_type` are don't-care, except after reset.
- `m_data`/`m_type` are stable while `m_valid && !m_ready`.
- `eng_halt` register next value: `(count_next >= DEPTH-SKID)`, where `count_next` is the post-update occupancy.
- `overflow`: set has priority over `clr_overflow` in the same cycle. It holds otherwise.
- Storage array is not reset. Only pointers, `count`, `eng_halt`, `overflow` and the stats counters are reset.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_type`=INVALID, `count`=0, `eng_halt`=0, `overflow`=0, `enc_cnt`=`dec_cnt`=0.
- Asynchronous reset takes effect immediately. Any FIFO contents are discarded and in-flight engine results are not recovered.
- Latency: a result sampled at posedge N is visible on `m_valid`/`m_data` after posedge N when the FIFO was empty (one cycle, zero bubbles).
- Throughput: one push and one pop per cycle sustained.
- Halt: `eng_halt` rises on the posedge where occupancy reaches DEPTH-SKID. It falls on the posedge where occupancy drops below DEPTH-SKID.
- Up to SKID results may still arrive after the threshold is reached without overflow.

## Configuration
- `AES_OUT_FIFO_STATS_EN` defined:
  - `enc_cnt`/`dec_cnt` ports exist.
  - Each increments by 1 on every accepted push of ENCRYPT/DECRYPT respectively.
  - Each wraps 16'hFFFF→0. Dropped results are not counted.
- Not defined: ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset check: reset with `eng_out_type`=ENCRYPT → all outputs at reset values; no capture while `rst_n`=0.
- Single pass-through (DEPTH=8):
  - Stimulus: `eng_out`=128'h69c4e0d86a7b0430d8cdb78070b4c55a, ENCRYPT for one cycle; `m_ready`=1.
  - Response: `m_valid`=1 for exactly one cycle with that data and ENCRYPT; `count` returns to 0.
- INVALID filtering: alternate ENCRYPT/INVALID/DECRYPT/INVALID with `m_ready`=0 → `count`=2; head is the ENCRYPT entry, then the DECRYPT entry.
- Backpressure (DEPTH=8, SKID=2), `m_ready`=0, continuous ENCRYPT:
  - `eng_halt` rises after the 6th push.
  - The bench models the engine as producing 2 more results → `count`=8, `overflow`=0.
  - A 9th result → `overflow`=1 and `count` stays 8.
  - `clr_overflow` pulse → `overflow`=0.
- Full with simultaneous push/pop: `count`=8, `m_ready`=1, DECRYPT arriving → `count` stays 8, no overflow; pop order equals push order across pointer wrap (≥20 entries streamed).
- Stats (macro defined): 5 ENCRYPT + 3 DECRYPT accepted → `enc_cnt`=5, `dec_cnt`=3; preload `enc_cnt`=16'hFFFF via 65535 pushes → next push gives 0.

Source files
------------

// File: rtl/aes_out_fifo.sv
// Result buffer between aes_engine and its consumer: filters INVALID slots, halts the engine early.
// Optional enc_cnt/dec_cnt statistics are built when AES_OUT_FIFO_STATS_EN is defined.

package aes_out_fifo_pkg;
  typedef enum logic [1:0] {
    INVALID = 2'd0,
    ENCRYPT = 2'd1,
    DECRYPT = 2'd2
  } job_t;
endpackage

module aes_out_fifo
  import aes_out_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SKID  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [127:0]               eng_out,
  input  job_t                       eng_out_type,
  output logic                       eng_halt,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [127:0]               m_data,
  output job_t                       m_type,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
`ifdef AES_OUT_FIFO_STATS_EN
  output logic [15:0]                enc_cnt,
  output logic [15:0]                dec_cnt,
`endif
  input  logic                       clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(DEPTH - SKID);

  logic [127:0]  data_mem [DEPTH];
  job_t          type_mem [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          halt_q, halt_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, accept;
`ifdef AES_OUT_FIFO_STATS_EN
  logic [15:0]   enc_cnt_q, enc_cnt_d;
  logic [15:0]   dec_cnt_q, dec_cnt_d;
`endif

  assign m_valid  = (count_q != '0);
  // Outputs are forced to reset values while empty, since the storage itself is never reset.
  assign m_data   = m_valid ? data_mem[rptr_q] : '0;
  assign m_type   = m_valid ? type_mem[rptr_q] : INVALID;
  assign count    = count_q;
  assign eng_halt = halt_q;
  assign overflow = overflow_q;

  always_comb begin
    push   = (eng_out_type == ENCRYPT) || (eng_out_type == DECRYPT);
    pop    = m_valid && m_ready;
    accept = push && ((count_q != FULL_C) || pop);

    wptr_d = accept ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + AW'(1) : rptr_q;

    count_d = count_q;
    if (accept && !pop)      count_d = count_q + CW'(1);
    else if (!accept && pop) count_d = count_q - CW'(1);

    halt_d = (count_d >= THRESH_C);

    overflow_d = overflow_q;
    if (push && !accept)   overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;

`ifdef AES_OUT_FIFO_STATS_EN
    enc_cnt_d = enc_cnt_q;
    dec_cnt_d = dec_cnt_q;
    if (accept && eng_out_type == ENCRYPT) enc_cnt_d = enc_cnt_q + 16'd1;
    if (accept && eng_out_type == DECRYPT) dec_cnt_d = dec_cnt_q + 16'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_mem[wptr_q] <= eng_out;
      type_mem[wptr_q] <= eng_out_type;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      halt_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef AES_OUT_FIFO_STATS_EN
      enc_cnt_q  <= '0;
      dec_cnt_q  <= '0;
`endif
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      halt_q     <= halt_d;
      overflow_q <= overflow_d;
`ifdef AES_OUT_FIFO_STATS_EN
      enc_cnt_q  <= enc_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
`endif
    end
  end

`ifdef AES_OUT_FIFO_STATS_EN
  assign enc_cnt = enc_cnt_q;
  assign dec_cnt = dec_cnt_q;
`endif

endmodule

// File: tb/tb_aes_out_fifo.sv
// Scoreboard bench for aes_out_fifo (DEPTH=8, SKID=2); stats checks build with AES_OUT_FIFO_STATS_EN.

module tb_aes_out_fifo;
  import aes_out_fifo_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [127:0] eng_out;
  job_t         eng_out_type;
  logic         eng_halt;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  job_t         m_type;
  logic [3:0]   count;
  logic         overflow;
  logic         clr_overflow;
`ifdef AES_OUT_FIFO_STATS_EN
  logic [15:0]  enc_cnt;
  logic [15:0]  dec_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] d;
    job_t         t;
  } exp_t;
  exp_t sb[$];

  aes_out_fifo #(.DEPTH(8), .SKID(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .eng_out      (eng_out),
    .eng_out_type (eng_out_type),
    .eng_halt     (eng_halt),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_type       (m_type),
    .count        (count),
    .overflow     (overflow),
`ifdef AES_OUT_FIFO_STATS_EN
    .enc_cnt      (enc_cnt),
    .dec_cnt      (dec_cnt),
`endif
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one engine slot for one posedge; queue the expectation if it should be accepted.
  task automatic cyc(input job_t t, input logic [127:0] d, input logic rdy, input logic exp_push);
    exp_t e;
    eng_out_type = t;
    eng_out      = d;
    m_ready      = rdy;
    if (exp_push) begin
      e.d = d;
      e.t = t;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    eng_out_type = INVALID;
    eng_out      = '0;
  endtask

  // Monitor: every handshake pops the scoreboard and compares head data/type.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %h with empty scoreboard", m_data);
      end else begin
        e = sb.pop_front();
        chk("pop_data", m_data, e.d);
        chk("pop_type", 128'(m_type), 128'(e.t));
      end
    end
  end

  localparam logic [127:0] KAT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    rst_n        = 1'b0;
    eng_out      = KAT;
    eng_out_type = ENCRYPT;
    m_ready      = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 128'(m_valid), 128'd0);
    chk("rst_m_data", m_data, 128'd0);
    chk("rst_m_type", 128'(m_type), 128'(INVALID));
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_halt", 128'(eng_halt), 128'd0);
    chk("rst_overflow", 128'(overflow), 128'd0);
    eng_out_type = INVALID;
    eng_out      = '0;
    rst_n        = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_count", 128'(count), 128'd0);

    // single pass-through
    cyc(ENCRYPT, KAT, 1'b1, 1'b1);
    chk("pt_valid", 128'(m_valid), 128'd1);
    chk("pt_count1", 128'(count), 128'd1);
    chk("pt_data", m_data, KAT);
    cyc(INVALID, '0, 1'b1, 1'b0);
    chk("pt_valid_off", 128'(m_valid), 128'd0);
    chk("pt_count0", 128'(count), 128'd0);

    // INVALID filtering
    cyc(ENCRYPT, 128'hA1, 1'b0, 1'b1);
    cyc(INVALID, 128'hBAD1, 1'b0, 1'b0);
    cyc(DECRYPT, 128'hD2, 1'b0, 1'b1);
    cyc(INVALID, 128'hBAD2, 1'b0, 1'b0);
    chk("flt_count", 128'(count), 128'd2);
    chk("flt_head_data", m_data, 128'hA1);
    chk("flt_head_type", 128'(m_type), 128'(ENCRYPT));
    cyc(INVALID, '0, 1'b1, 1'b0);
    chk("flt_head2_type", 128'(m_type), 128'(DECRYPT));
    cyc(INVALID, '0, 1'b1, 1'b0);
    chk("flt_drained", 128'(count), 128'd0);

    // backpressure: halt at 6, two skid results, then overflow
    for (int i = 1; i <= 6; i++) begin
      cyc(ENCRYPT, 128'(100 + i), 1'b0, 1'b1);
      chk("bp_halt", 128'(eng_halt), (i >= 6) ? 128'd1 : 128'd0);
    end
    chk("bp_count6", 128'(count), 128'd6);
    cyc(ENCRYPT, 128'd107, 1'b0, 1'b1);
    cyc(ENCRYPT, 128'd108, 1'b0, 1'b1);
    chk("bp_count8", 128'(count), 128'd8);
    chk("bp_no_ovf", 128'(overflow), 128'd0);
    cyc(ENCRYPT, 128'd109, 1'b0, 1'b0);
    chk("bp_count_full", 128'(count), 128'd8);
    chk("bp_ovf", 128'(overflow), 128'd1);
    cyc(INVALID, '0, 1'b0, 1'b0);
    chk("bp_ovf_sticky", 128'(overflow), 128'd1);
    clr_overflow = 1'b1;
    cyc(INVALID, '0, 1'b0, 1'b0);
    clr_overflow = 1'b0;
    chk("bp_ovf_clr", 128'(overflow), 128'd0);

    // full with simultaneous push/pop, streamed across pointer wrap
    for (int i = 0; i < 20; i++) begin
      cyc(DECRYPT, 128'(128'hD000 + i), 1'b1, 1'b1);
      chk("full_count", 128'(count), 128'd8);
      chk("full_no_ovf", 128'(overflow), 128'd0);
    end
    for (int k = 1; k <= 8; k++) begin
      cyc(INVALID, '0, 1'b1, 1'b0);
      chk("drain_count", 128'(count), 128'(8 - k));
      chk("drain_halt", 128'(eng_halt), ((8 - k) >= 6) ? 128'd1 : 128'd0);
    end

`ifdef AES_OUT_FIFO_STATS_EN
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("st_rst_enc", 128'(enc_cnt), 128'd0);
    for (int i = 0; i < 5; i++) cyc(ENCRYPT, 128'(i), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(DECRYPT, 128'(i + 50), 1'b1, 1'b1);
    chk("st_enc5", 128'(enc_cnt), 128'd5);
    chk("st_dec3", 128'(dec_cnt), 128'd3);
    for (int i = 0; i < 65530; i++) cyc(ENCRYPT, 128'(i), 1'b1, 1'b1);
    chk("st_enc_max", 128'(enc_cnt), 128'hFFFF);
    cyc(ENCRYPT, 128'hF00D, 1'b1, 1'b1);
    chk("st_enc_wrap", 128'(enc_cnt), 128'd0);
    chk("st_dec_hold", 128'(dec_cnt), 128'd3);
    cyc(INVALID, '0, 1'b1, 1'b0);
    cyc(INVALID, '0, 1'b1, 1'b0);
`endif

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
